// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer: arbitrates ALU/load writebacks into an in-order FIFO and retires one register file write per cycle.
module regfile_wb_writer #(
  parameter int DATAWIDTH  = 64,
  parameter int ADDRWIDTH  = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int PTRW       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDRWIDTH-1:0] ld_addr,
  input  logic [0:DATAWIDTH-1] ld_data,
  input  logic [2:0]           ld_ppp,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDRWIDTH-1:0] alu_addr,
  input  logic [0:DATAWIDTH-1] alu_data,
  input  logic [2:0]           alu_ppp,
  output logic                 rf_write_enb,
  output logic [0:DATAWIDTH-1] rf_data_in,
  output logic [2:0]           rf_pppsel,
  output logic [ADDRWIDTH-1:0] rf_addr_wr,
  input  logic [ADDRWIDTH-1:0] chk_addr_0,
  input  logic [ADDRWIDTH-1:0] chk_addr_1,
  output logic                 hazard_0,
  output logic                 hazard_1,
  output logic [PTRW:0]        count
);
  logic [ADDRWIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [0:DATAWIDTH-1] data_q [FIFO_DEPTH];
  logic [2:0]           ppp_q  [FIFO_DEPTH];
  logic [PTRW-1:0]      rd_q, rd_d, wr_q, wr_d, off;
  logic [PTRW:0]        count_q, count_d;
  logic                 full, acc_ld, acc_alu, push, pop, drain_stall;
  logic [ADDRWIDTH-1:0] in_addr;
  logic [0:DATAWIDTH-1] in_data;
  logic [2:0]           in_ppp;
  // Held low in the design; a bench may force it high to back up the FIFO.
  assign drain_stall = 1'b0;
  assign full      = count_q == (PTRW+1)'(FIFO_DEPTH);
  assign ld_ready  = !full && !reset;
  assign alu_ready = !full && !ld_valid && !reset;
  assign acc_ld    = ld_valid && ld_ready;
  assign acc_alu   = alu_valid && alu_ready;
  assign in_addr   = acc_ld ? ld_addr : alu_addr;
  assign in_data   = acc_ld ? ld_data : alu_data;
  assign in_ppp    = acc_ld ? ld_ppp : alu_ppp;
  assign push      = (acc_ld || acc_alu) && in_addr != '0 && in_ppp <= 3'd4;
  assign pop       = count_q != '0 && !drain_stall;
  assign count_d   = count_q + (PTRW+1)'(push) - (PTRW+1)'(pop);
  assign rd_d      = rd_q + PTRW'(pop);
  assign wr_d      = wr_q + PTRW'(push);
  assign count     = count_q;
  // An entry is occupied when its distance from the read pointer is below count.
  always_comb begin
    hazard_0 = 1'b0;
    hazard_1 = 1'b0;
    off = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTRW'(i) - rd_q;
      hazard_0 = hazard_0 || ({1'b0, off} < count_q && addr_q[i] == chk_addr_0);
      hazard_1 = hazard_1 || ({1'b0, off} < count_q && addr_q[i] == chk_addr_1);
    end
    hazard_0 = hazard_0 && chk_addr_0 != '0;
    hazard_1 = hazard_1 && chk_addr_1 != '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      rf_write_enb <= 1'b0;
      rf_data_in <= '0;
      rf_pppsel <= '0;
      rf_addr_wr <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      rf_write_enb <= pop;
      if (pop) begin
        rf_data_in <= data_q[rd_q];
        rf_pppsel <= ppp_q[rd_q];
        rf_addr_wr <= addr_q[rd_q];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_q] <= in_addr;
      data_q[wr_q] <= in_data;
      ppp_q[wr_q] <= in_ppp;
    end
  end
endmodule

// File: tb/tb_regfile_wb_writer.sv
// tb_regfile_wb_writer: queue-based model of the writeback buffer checked every cycle, plus directed literal checks.
module tb_regfile_wb_writer;
  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
    logic [2:0]  ppp;
  } wr_t;
  logic clk = 1'b0, reset;
  logic ld_valid, alu_valid, ld_ready, alu_ready, rf_write_enb, hazard_0, hazard_1;
  logic [4:0] ld_addr, alu_addr, rf_addr_wr, chk_addr_0, chk_addr_1;
  logic [63:0] ld_data, alu_data, rf_data_in;
  logic [2:0] ld_ppp, alu_ppp, rf_pppsel;
  logic [2:0] count;
  int checks = 0, errors = 0;
  bit go = 0, stall = 0;
  wr_t q[$];
  wr_t e;
  int n;
  logic ewe;
  logic [4:0] eaddr;
  logic [63:0] edata;
  logic [2:0] eppp;
  logic [63:0] rf_m [32];
  logic h0, h1;

  regfile_wb_writer dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ppp(ld_ppp),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ppp(alu_ppp),
    .rf_write_enb(rf_write_enb), .rf_data_in(rf_data_in), .rf_pppsel(rf_pppsel), .rf_addr_wr(rf_addr_wr),
    .chk_addr_0(chk_addr_0), .chk_addr_1(chk_addr_1), .hazard_0(hazard_0), .hazard_1(hazard_1),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lane_mask(logic [2:0] p);
    return p == 3'd0 ? 64'hFFFFFFFF_FFFFFFFF : p == 3'd1 ? 64'hFFFFFFFF_00000000 :
           p == 3'd2 ? 64'h00000000_FFFFFFFF : p == 3'd3 ? 64'hFF00FF00_FF00FF00 :
           p == 3'd4 ? 64'h00FF00FF_00FF00FF : 64'h0;
  endfunction

  // Model: pop the head if anything is buffered, then enqueue the winning legal result.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      ewe = 0; eaddr = 0; edata = 0; eppp = 0;
      go = 1;
    end else begin
      n = q.size();
      if (n > 0 && !stall) begin
        e = q.pop_front();
        ewe = 1; eaddr = e.addr; edata = e.data; eppp = e.ppp;
      end else ewe = 0;
      if (n < 4 && ld_valid) begin
        if (ld_addr != 0 && ld_ppp < 5) q.push_back('{ld_addr, ld_data, ld_ppp});
      end else if (n < 4 && alu_valid) begin
        if (alu_addr != 0 && alu_ppp < 5) q.push_back('{alu_addr, alu_data, alu_ppp});
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      h0 = 0; h1 = 0;
      foreach (q[i]) begin
        if (chk_addr_0 != 0 && q[i].addr == chk_addr_0) h0 = 1;
        if (chk_addr_1 != 0 && q[i].addr == chk_addr_1) h1 = 1;
      end
      chk("m_count", 64'(count), 64'(q.size()));
      chk("m_ld_ready", 64'(ld_ready), 64'(!reset && q.size() < 4));
      chk("m_alu_ready", 64'(alu_ready), 64'(!reset && q.size() < 4 && !ld_valid));
      chk("m_we", 64'(rf_write_enb), 64'(ewe));
      chk("m_addr", 64'(rf_addr_wr), 64'(eaddr));
      chk("m_data", rf_data_in, edata);
      chk("m_ppp", 64'(rf_pppsel), 64'(eppp));
      chk("m_haz0", 64'(hazard_0), 64'(h0));
      chk("m_haz1", 64'(hazard_1), 64'(h1));
    end
    if (rf_write_enb === 1'b1)
      rf_m[rf_addr_wr] = (rf_m[rf_addr_wr] & ~lane_mask(rf_pppsel)) | (rf_data_in & lane_mask(rf_pppsel));
  end

  initial begin
    foreach (rf_m[i]) rf_m[i] = 64'h0;
    reset = 1; ld_valid = 0; alu_valid = 0;
    ld_addr = 0; ld_data = 0; ld_ppp = 0; alu_addr = 0; alu_data = 0; alu_ppp = 0;
    chk_addr_0 = 0; chk_addr_1 = 0;
    repeat (3) step();
    chk("rst_count", 64'(count), 0);
    chk("rst_ld_ready", 64'(ld_ready), 0);
    chk("rst_we", 64'(rf_write_enb), 0);
    reset = 0;
    #1 chk("rel_ld_ready", 64'(ld_ready), 1);
    // single load
    ld_valid = 1; ld_addr = 5; ld_data = 64'h0123_4567_89AB_CDEF; ld_ppp = 0; chk_addr_0 = 5;
    #1 chk("single_haz_before", 64'(hazard_0), 0);
    step();
    ld_valid = 0;
    #1 chk("single_haz", 64'(hazard_0), 1);
    chk("single_count", 64'(count), 1);
    chk("single_we0", 64'(rf_write_enb), 0);
    step();
    chk("single_we", 64'(rf_write_enb), 1);
    chk("single_addr", 64'(rf_addr_wr), 5);
    chk("single_data", rf_data_in, 64'h0123_4567_89AB_CDEF);
    chk("single_haz_after", 64'(hazard_0), 0);
    step();
    chk("single_we_off", 64'(rf_write_enb), 0);
    chk_addr_0 = 0;
    // arbitration
    ld_valid = 1; ld_addr = 3; ld_data = 64'h33; alu_valid = 1; alu_addr = 4; alu_data = 64'h44; alu_ppp = 0;
    #1 chk("arb_ld_ready", 64'(ld_ready), 1);
    chk("arb_alu_ready", 64'(alu_ready), 0);
    step();
    ld_valid = 0;
    #1 chk("arb_alu_ready2", 64'(alu_ready), 1);
    step();
    alu_valid = 0;
    chk("arb_first", 64'(rf_addr_wr), 3);
    step();
    chk("arb_second", 64'(rf_addr_wr), 4);
    chk("arb_second_data", rf_data_in, 64'h44);
    // filtering
    alu_valid = 1; alu_addr = 0; alu_ppp = 0;
    #1 chk("filt_alu_ready", 64'(alu_ready), 1);
    step();
    alu_valid = 0; ld_valid = 1; ld_addr = 9; ld_ppp = 3'b110;
    chk("filt_we1", 64'(rf_write_enb), 0);
    chk("filt_ld_ready", 64'(ld_ready), 1);
    step();
    ld_valid = 0; ld_ppp = 0;
    chk("filt_count", 64'(count), 0);
    step();
    chk("filt_we2", 64'(rf_write_enb), 0);
    // ordering
    ld_valid = 1; ld_addr = 7; ld_ppp = 1; ld_data = 64'hAAAA_AAAA_0000_0000;
    step();
    ld_ppp = 2; ld_data = 64'h0000_0000_BBBB_BBBB;
    step();
    ld_valid = 0; ld_ppp = 0;
    chk("ord_first_addr", 64'(rf_addr_wr), 7);
    chk("ord_first_ppp", 64'(rf_pppsel), 1);
    step();
    chk("ord_second_ppp", 64'(rf_pppsel), 2);
    chk("ord_second_we", 64'(rf_write_enb), 1);
    step();
    chk("ord_rf_r7", rf_m[7], 64'hAAAA_AAAA_BBBB_BBBB);
    // full FIFO with drain held off
    force dut.drain_stall = 1'b1; stall = 1;
    ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ld_addr = 5'(10 + i); ld_data = 64'h1000 + 64'(i);
      step();
    end
    ld_addr = 14; alu_valid = 1; alu_addr = 15; chk_addr_1 = 12;
    #1 chk("full_count", 64'(count), 4);
    chk("full_ld_ready", 64'(ld_ready), 0);
    chk("full_alu_ready", 64'(alu_ready), 0);
    chk("full_haz1", 64'(hazard_1), 1);
    chk("full_we", 64'(rf_write_enb), 0);
    step();
    chk("full_hold", 64'(count), 4);
    ld_valid = 0; alu_valid = 0;
    release dut.drain_stall; stall = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_we", 64'(rf_write_enb), 1);
      chk("drain_addr", 64'(rf_addr_wr), 64'(10 + i));
      chk("drain_data", rf_data_in, 64'h1000 + 64'(i));
    end
    step();
    chk("drain_done", 64'(count), 0);
    chk_addr_1 = 0;
    // reset with a backlog
    force dut.drain_stall = 1'b1; stall = 1;
    ld_valid = 1; ld_addr = 20; ld_data = 64'h20;
    step();
    ld_addr = 21; ld_data = 64'h21;
    step();
    ld_valid = 0;
    chk("pre_rst_count", 64'(count), 2);
    chk("pre_rst_addr", 64'(rf_addr_wr), 13);
    reset = 1;
    step();
    chk("mid_rst_count", 64'(count), 0);
    chk("mid_rst_we", 64'(rf_write_enb), 0);
    chk("mid_rst_addr", 64'(rf_addr_wr), 0);
    chk("mid_rst_data", rf_data_in, 0);
    chk("mid_rst_ppp", 64'(rf_pppsel), 0);
    chk("mid_rst_ld_ready", 64'(ld_ready), 0);
    chk("mid_rst_alu_ready", 64'(alu_ready), 0);
    reset = 0;
    release dut.drain_stall; stall = 0;
    #1 chk("post_rst_ld_ready", 64'(ld_ready), 1);
    chk("post_rst_alu_ready", 64'(alu_ready), 1);
    repeat (2) step();
    chk("post_rst_we", 64'(rf_write_enb), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_writer.md
# regfile_wb_writer

Write-side driver for the 32 x 64-bit register file. It collects writeback results from the ALU and the load unit over valid/ready handshakes and buffers them in a small in-order FIFO. It retires one write per cycle onto the register file write port (`write_enb`, `data_in`, `pppsel`, `addr_wr`). It also gives decode a hazard indication for reads that would miss a still-buffered write.

## Interface
- `DATAWIDTH`, 64, data width; bit 0 is the MSB, matching the register file.
- `ADDRWIDTH`, 5, register address width.
- `FIFO_DEPTH`, 4, buffer entries; must be a power of 2.
- `PTRW`, 2, log2(`FIFO_DEPTH`).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `ld_valid` in 1: load result valid.
- `ld_ready` out 1: load result accepted when high together with `ld_valid`.
- `ld_addr` in `ADDRWIDTH`: load destination register.
- `ld_data` in `DATAWIDTH`: load result data.
- `ld_ppp` in 3: load selective-write mode.
- `alu_valid` in 1: ALU result valid.
- `alu_ready` out 1: ALU result accepted when high together with `alu_valid`.
- `alu_addr` in `ADDRWIDTH`: ALU destination register.
- `alu_data` in `DATAWIDTH`: ALU result data.
- `alu_ppp` in 3: ALU selective-write mode.
- `rf_write_enb` out 1: register file write enable.
- `rf_data_in` out `DATAWIDTH`: register file write data.
- `rf_pppsel` out 3: register file write mode.
- `rf_addr_wr` out `ADDRWIDTH`: register file write address.
- `chk_addr_0` in `ADDRWIDTH`: decode read address, port 0.
- `chk_addr_1` in `ADDRWIDTH`: decode read address, port 1.
- `hazard_0` out 1: port 0 read matches a buffered write.
- `hazard_1` out 1: port 1 read matches a buffered write.
- `count` out `PTRW+1`: current FIFO occupancy.

## Operation
- **Write modes.** Valid `pppsel` codes are 000 (all 64 bits), 001 (upper 32), 010 (lower 32), 011 (even bytes) and 100 (odd bytes). Codes 101–111 are illegal.
- **Arbitration.** At most one result is accepted per cycle, and the load unit has fixed priority.
  - `ld_ready = !full && !reset`.
  - `alu_ready = !full && !ld_valid && !reset`.
  - `full` means `count == FIFO_DEPTH`.
- **Filtering.** An accepted result with address 0 or an illegal `ppp` code completes its handshake but is discarded: it is not enqueued and `count` does not change.
- **Enqueue.** Each FIFO entry holds {addr, data, ppp}. The write pointer increments modulo `FIFO_DEPTH` and wraps naturally.
- **Drain.** On every rising edge with `count > 0`, the head entry is popped into the registered `rf_*` outputs and `rf_write_enb` is set to 1. With `count == 0`, `rf_write_enb` is set to 0, and `rf_data_in`, `rf_addr_wr` and `rf_pppsel` hold their previous values.
- **Simultaneous push and pop.** `count` is unchanged and both pointers advance.
- **No bypass.** An empty FIFO does not forward input straight to the outputs; every accepted write passes through the FIFO.
- **Write order.** Writes retire in acceptance order. Two entries to the same address retire in order, so the later one wins per byte lane.
- **Hazards.** `hazard_k` is combinational.
  - It is 1 when `chk_addr_k != 0` and `chk_addr_k` equals the addr of any occupied FIFO entry.
  - The write currently on the `rf_*` outputs is not included, because the register file forwards it internally.
  - A handshake in the current cycle is not included either.
- **Reset.** Reset clears the pointers and `count`, drives every `rf_*` output to 0 and both ready outputs to 0. In-flight entries are dropped; a mid-operation reset loses all buffered writes.

## Timing
- An accept at edge t enqueues the result.
  - The entry is popped at edge t+1, so `rf_write_enb` is high between t+1 and t+2.
  - The register file commits at edge t+2.
  - Minimum latency is 2 cycles from handshake to commit.
- `hazard_k` for an entry is high from after edge t until edge t+1, i.e. the cycle it sits in the FIFO.
- Sustained throughput is 1 write per cycle, so `count` never exceeds 1 with uninterrupted draining.
- The FIFO absorbs bursts only when pop is blocked, which happens only after a reset release with a backlog (none). `FIFO_DEPTH` is sized for future stall-insertion and must still be verified full, using a test-only drain-stall force.
- The ready signals depend only on registered `count` and `ld_valid`. There is no combinational path from `rf_*` to `ready`.

## Test plan
- **Single load write.** Stimulus: `ld_valid` = 1, `ld_addr` = 5, `ld_data` = 64'h0123_4567_89AB_CDEF, `ld_ppp` = 000 at edge 0. Required: `rf_write_enb` = 1, `rf_addr_wr` = 5 and `rf_data_in` equal to that value between edges 1 and 2; `hazard_0` = 1 with `chk_addr_0` = 5 only between edges 0 and 1.
- **Arbitration.** Stimulus: both sources valid, ld to r3, alu to r4. Required: `ld_ready` = 1, `alu_ready` = 0, r3 is written first; the ALU result is accepted on the next edge and r4 is written one cycle later.
- **Filtering.** Stimulus: an ALU write to r0 with `ppp` 000, then a load with `ppp` 110. Required: both handshakes complete, `count` stays 0 and `rf_write_enb` never rises.
- **Ordering.** Stimulus: r7 with `ppp` 001 and data 64'hAAAA_AAAA_0000_0000, then r7 with `ppp` 010 and data 64'h0000_0000_BBBB_BBBB. Required: two consecutive writes in that order, and the register file reads r7 = 64'hAAAA_AAAA_BBBB_BBBB.
- **Full FIFO.** Stimulus: with drain forced off, push 4 entries. Required: `count` = 4, both readys = 0; after drain is released, 4 writes retire in order and the pointers wrap.
- **Reset mid-operation.** Stimulus: assert `reset` with `count` = 2. Required: after the edge, `count` = 0, all `rf_*` outputs = 0, readys = 0 while reset is held and 1 after release.
